stream_writer: RTL and testbench



---
 rtl/stream_writer.sv | 161 ++++++++++++++++
 tb/tb_stream_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_writer.sv
// stream_writer
//   Takes a valid/ready data stream and writes each beat to consecutive
//   memory addresses. The range starts at START and stops before LIMIT.
//   A one-cycle DONE pulse marks normal completion.
//
// Ports
//   CLOCK, RESET       rising-edge clock, asynchronous active-high reset
//   GO, START, LIMIT   start request and address range; sampled in IDLE only
//   ABORT              cancels a running transfer without raising DONE
//   S_DATA/S_VALID/S_READY  input stream
//   WADDR/WDATA/WE     memory write port; written one cycle after acceptance
//   COUNT              beats accepted in the current or last transfer
//   BUSY               high while the writer is in RUN
//   DONE               one-cycle completion pulse, aligned with the last WE
//   ERR                one-cycle pulse when LIMIT < START
//   DBG_STATE          current FSM state (0 IDLE, 1 RUN, 2 FIN)
//
// Handshake: a beat moves on any rising edge where S_VALID && S_READY.
// The producer holds S_DATA steady while S_VALID is high and S_READY is low.
// S_READY is decoded directly from the state register and ABORT. It never
// depends on S_VALID.
module stream_writer #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              GO,
  input  logic              ABORT,
  input  logic [AWIDTH-1:0] START,
  input  logic [AWIDTH-1:0] LIMIT,
  input  logic [DWIDTH-1:0] S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic [AWIDTH-1:0] WADDR,
  output logic [DWIDTH-1:0] WDATA,
  output logic              WE,
  output logic [AWIDTH-1:0] COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [AWIDTH-1:0] ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [AWIDTH-1:0] end_q, end_d;
  logic [AWIDTH-1:0] count_q, count_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              s_ready;
  logic              xfer;
  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH-1:0] nxt_addr;

  // ABORT blocks acceptance in the same cycle it appears.
  assign s_ready  = (state_q == ST_RUN) && !ABORT;
  assign xfer     = S_VALID && s_ready;
  assign cur_addr = base_q + count_q;
  assign nxt_addr = cur_addr + ONE;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    end_d   = end_q;
    count_d = count_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // GO takes priority over ABORT here because ABORT only acts in RUN.
        if (GO) begin
          base_d  = START;
          end_d   = LIMIT;
          count_d = '0;
          if (LIMIT > START) begin
            state_d = ST_RUN;
          end else if (LIMIT == START) begin
            // Zero-length transfer: pass through FIN with no writes.
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          we_d    = 1'b1;
          waddr_d = cur_addr;
          wdata_d = S_DATA;
          count_d = count_q + ONE;
          // DONE is registered on the same edge as the last WE, so the
          // two pulses line up in the FIN cycle.
          if (nxt_addr == end_q) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      end_q   <= '0;
      count_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      end_q   <= end_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign S_READY   = s_ready;
  assign WADDR     = waddr_q;
  assign WDATA     = wdata_q;
  assign WE        = we_q;
  assign COUNT     = count_q;
  assign BUSY      = (state_q == ST_RUN);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_stream_writer.sv
// Testbench for stream_writer. Inputs change 1 time unit after each rising
// edge. Outputs are sampled on the falling edge. The reference model below
// works from transfer bookkeeping: beats remaining, base, and count.
module tb_stream_writer;

  logic        CLOCK;
  logic        RESET;
  logic        GO;
  logic        ABORT;
  logic [31:0] START;
  logic [31:0] LIMIT;
  logic [7:0]  S_DATA;
  logic        S_VALID;
  logic        S_READY;
  logic [31:0] WADDR;
  logic [7:0]  WDATA;
  logic        WE;
  logic [31:0] COUNT;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [1:0]  DBG_STATE;

  int errors = 0;
  int checks = 0;

  stream_writer #(.DWIDTH(8), .AWIDTH(32)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .GO(GO), .ABORT(ABORT),
    .START(START), .LIMIT(LIMIT), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_READY(S_READY), .WADDR(WADDR), .WDATA(WDATA), .WE(WE),
    .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy;
  logic [31:0] m_rem;
  logic [31:0] m_base;
  logic [31:0] m_cnt;
  logic        exp_we;
  logic        exp_done;
  logic        exp_err;
  logic [31:0] exp_waddr;
  logic [7:0]  exp_wdata;

  // Observed write log, plus pulse counters, for the literal expectations.
  logic [31:0] obs_addr_q[$];
  logic [7:0]  obs_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_q[$];
  int done_cnt;
  int err_cnt;
  int done_we_cnt;

  task automatic model_reset();
    m_busy    = 1'b0;
    m_rem     = '0;
    m_base    = '0;
    m_cnt     = '0;
    exp_we    = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  initial model_reset();

  always @(negedge CLOCK) begin
    logic n_we, n_done, n_err;
    if (RESET) begin
      model_reset();
    end
    chk("we", WE, exp_we);
    chk("done", DONE, exp_done);
    chk("err", ERR, exp_err);
    chk("busy", BUSY, m_busy);
    chk("s_ready", S_READY, m_busy && !ABORT);
    chk("count", COUNT, m_cnt);
    if (exp_we) begin
      chk("waddr", WADDR, exp_waddr);
      chk("wdata", WDATA, exp_wdata);
    end
    if (!RESET) begin
      if (WE) begin
        obs_addr_q.push_back(WADDR);
        obs_data_q.push_back(WDATA);
      end
      if (DONE) done_cnt++;
      if (ERR) err_cnt++;
      if (DONE && WE) done_we_cnt++;
      // Work out what the next rising edge must produce from this cycle's inputs.
      n_we = 1'b0; n_done = 1'b0; n_err = 1'b0;
      if (m_busy) begin
        if (ABORT) begin
          m_busy = 1'b0;
        end else if (S_VALID) begin
          n_we      = 1'b1;
          exp_waddr = m_base + m_cnt;
          exp_wdata = S_DATA;
          m_cnt     = m_cnt + 1;
          m_rem     = m_rem - 1;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            n_done = 1'b1;
          end
        end
      end else if (!exp_done && GO) begin
        m_cnt  = '0;
        m_base = START;
        if (LIMIT > START) begin
          m_rem  = LIMIT - START;
          m_busy = 1'b1;
        end else if (LIMIT == START) begin
          n_done = 1'b1;
        end else begin
          n_err = 1'b1;
        end
      end
      exp_we   = n_we;
      exp_done = n_done;
      exp_err  = n_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic g, input logic v, input logic [7:0] d, input logic ab);
    GO = g; S_VALID = v; S_DATA = d; ABORT = ab;
    @(posedge CLOCK); #1;
  endtask

  task automatic clear_log();
    obs_addr_q.delete(); obs_data_q.delete();
    exp_addr_q.delete(); exp_q.delete();
    done_cnt = 0; err_cnt = 0; done_we_cnt = 0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic check_log(input string name, input int exp_done_n, input int exp_err_n);
    chk({name, "_nwrites"}, obs_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size(); i++) begin
      if (i < obs_addr_q.size()) begin
        chk({name, "_addr"}, obs_addr_q[i], exp_addr_q[i]);
        chk({name, "_data"}, obs_data_q[i], exp_q[i]);
      end
    end
    chk({name, "_done_pulses"}, done_cnt, exp_done_n);
    chk({name, "_err_pulses"}, err_cnt, exp_err_n);
    chk({name, "_idle_state"}, DBG_STATE, 2'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    RESET = 1'b1; GO = 0; ABORT = 0; START = 0; LIMIT = 0; S_DATA = 0; S_VALID = 0;
    clear_log();
    repeat (3) @(posedge CLOCK);
    #1;
    chk("reset_waddr", WADDR, 32'h0);
    chk("reset_state", DBG_STATE, 2'd0);
    RESET = 1'b0;
    cyc(0, 0, 8'h00, 0);

    // Basic transfer of four beats.
    clear_log();
    START = 32'h10; LIMIT = 32'h14;
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hA0, 0); cyc(0, 1, 8'hA1, 0); cyc(0, 1, 8'hA2, 0); cyc(0, 1, 8'hA3, 0);
    repeat (3) cyc(0, 0, 8'h00, 0);
    expect_write(32'h10, 8'hA0); expect_write(32'h11, 8'hA1);
    expect_write(32'h12, 8'hA2); expect_write(32'h13, 8'hA3);
    check_log("basic", 1, 0);
    chk("basic_count", COUNT, 32'd4);
    chk("basic_done_with_we", done_we_cnt, 1);

    // Backpressure gaps with valid pattern 1,0,0,1,0,1.
    clear_log();
    START = 32'h0; LIMIT = 32'h3;
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'h11, 0); cyc(0, 0, 8'h12, 0); cyc(0, 0, 8'h13, 0);
    cyc(0, 1, 8'h14, 0); cyc(0, 0, 8'h15, 0); cyc(0, 1, 8'h16, 0);
    repeat (3) cyc(0, 1, 8'h77, 0);
    expect_write(32'h0, 8'h11); expect_write(32'h1, 8'h14); expect_write(32'h2, 8'h16);
    check_log("gaps", 1, 0);
    chk("gaps_count", COUNT, 32'd3);

    // Zero-length transfer.
    clear_log();
    START = 32'h20; LIMIT = 32'h20;
    cyc(1, 0, 8'h00, 0);
    chk("zero_done_next", DONE, 1'b1);
    repeat (2) cyc(0, 0, 8'h00, 0);
    check_log("zero", 1, 0);
    chk("zero_count", COUNT, 32'd0);

    // Illegal range.
    clear_log();
    START = 32'h30; LIMIT = 32'h20;
    cyc(1, 0, 8'h00, 0);
    chk("err_pulse_next", ERR, 1'b1);
    chk("err_busy", BUSY, 1'b0);
    repeat (2) cyc(0, 1, 8'h55, 0);
    check_log("err", 0, 1);

    // Abort after the third accepted beat, then restart.
    clear_log();
    START = 32'h0; LIMIT = 32'h8;
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hB0, 0); cyc(0, 1, 8'hB1, 0); cyc(0, 1, 8'hB2, 0);
    cyc(0, 1, 8'hB3, 1);
    repeat (2) cyc(0, 1, 8'hB4, 0);
    expect_write(32'h0, 8'hB0); expect_write(32'h1, 8'hB1); expect_write(32'h2, 8'hB2);
    check_log("abort", 0, 0);
    chk("abort_count", COUNT, 32'd3);
    clear_log();
    START = 32'h40; LIMIT = 32'h42;
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hC0, 0); cyc(0, 1, 8'hC1, 0);
    repeat (2) cyc(0, 0, 8'h00, 0);
    expect_write(32'h40, 8'hC0); expect_write(32'h41, 8'hC1);
    check_log("restart", 1, 0);
    chk("restart_count", COUNT, 32'd2);

    // A range that would wrap is rejected.
    clear_log();
    START = 32'hFFFF_FFFE; LIMIT = 32'h0000_0001;
    cyc(1, 0, 8'h00, 0);
    repeat (2) cyc(0, 0, 8'h00, 0);
    check_log("wrap_err", 0, 1);

    // Top-of-range transfer, with a GO and a new range ignored mid-run.
    clear_log();
    START = 32'hFFFF_FFFC; LIMIT = 32'hFFFF_FFFF;
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hD0, 0);
    START = 32'h0; LIMIT = 32'h5;
    cyc(1, 1, 8'hD1, 0);
    cyc(0, 1, 8'hD2, 0);
    repeat (2) cyc(0, 0, 8'h00, 0);
    expect_write(32'hFFFF_FFFC, 8'hD0); expect_write(32'hFFFF_FFFD, 8'hD1);
    expect_write(32'hFFFF_FFFE, 8'hD2);
    check_log("top", 1, 0);
    chk("top_count", COUNT, 32'd3);

    // Asynchronous reset in the middle of a run.
    clear_log();
    START = 32'h50; LIMIT = 32'h58;
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hE0, 0); cyc(0, 1, 8'hE1, 0);
    S_VALID = 1'b1; S_DATA = 8'hE2;
    #1;
    chk("pre_reset_we", WE, 1'b1);
    chk("pre_reset_count", COUNT, 32'd2);
    #1 RESET = 1'b1;
    #1;
    chk("areset_we", WE, 1'b0);
    chk("areset_ready", S_READY, 1'b0);
    chk("areset_busy", BUSY, 1'b0);
    chk("areset_count", COUNT, 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    expect_write(32'h50, 8'hE0);
    check_log("areset", 0, 0);
    clear_log();
    repeat (3) cyc(0, 1, 8'hE3, 0);
    check_log("post_reset", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
